// File: rtl/axi_interconnect_pkg.sv
// Shared AXI interconnect types: AR FSM state encoding, AR attribute widths
// and the packed attribute bundle carried through the read-address holding stage.
package axi_interconnect_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } ar_state_e;

  localparam int AR_SIZE_W   = 3;
  localparam int AR_BURST_W  = 2;
  localparam int AR_LOCK_W   = 2;
  localparam int AR_CACHE_W  = 4;
  localparam int AR_PROT_W   = 3;
  localparam int AR_QOS_W    = 4;
  localparam int AR_REGION_W = 4;

  // Fixed-width AR attributes; address and length widths are parameters of the user.
  typedef struct packed {
    logic [AR_SIZE_W-1:0]   size;
    logic [AR_BURST_W-1:0]  burst;
    logic [AR_LOCK_W-1:0]   lock;
    logic [AR_CACHE_W-1:0]  cache;
    logic [AR_PROT_W-1:0]   prot;
    logic [AR_QOS_W-1:0]    qos;
    logic [AR_REGION_W-1:0] region;
  } ar_attr_t;

endpackage

// File: rtl/ar_rr_arbiter.sv
// Combinational 2-way round-robin grant, one-hot output.
// With QOS_ARB_EN defined, the higher arqos wins contention before round-robin.
module ar_rr_arbiter
  import axi_interconnect_pkg::*;
(
  input  logic                valid0,
  input  logic                valid1,
  input  logic                last_grant,
`ifdef QOS_ARB_EN
  input  logic [AR_QOS_W-1:0] qos0,
  input  logic [AR_QOS_W-1:0] qos1,
`endif
  output logic [1:0]          grant
);

  logic pick1;

  always_comb begin
    pick1 = ~last_grant;
`ifdef QOS_ARB_EN
    if (qos0 > qos1)      pick1 = 1'b0;
    else if (qos1 > qos0) pick1 = 1'b1;
`endif
    if (valid0 && valid1) grant = pick1 ? 2'b10 : 2'b01;
    else                  grant = {valid1, valid0};
  end

endmodule

// File: rtl/read_addr_channel_arb.sv
// AR channel arbiter: round-robin between S00/S01 into a one-entry holding stage
// presented to the read address decoder. QOS_ARB_EN enables arqos-priority arbitration.
module read_addr_channel_arb
  import axi_interconnect_pkg::*;
#(
  parameter int Address_width   = 32,
  parameter int AXI4_AR_len     = 8,
  parameter int Masters_ID_Size = 1
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [Address_width-1:0]   S00_AXI_araddr,
  input  logic [AXI4_AR_len-1:0]     S00_AXI_arlen,
  input  logic [AR_SIZE_W-1:0]       S00_AXI_arsize,
  input  logic [AR_BURST_W-1:0]      S00_AXI_arburst,
  input  logic [AR_LOCK_W-1:0]       S00_AXI_arlock,
  input  logic [AR_CACHE_W-1:0]      S00_AXI_arcache,
  input  logic [AR_PROT_W-1:0]       S00_AXI_arprot,
  input  logic [AR_QOS_W-1:0]        S00_AXI_arqos,
  input  logic [AR_REGION_W-1:0]     S00_AXI_arregion,
  input  logic                       S00_AXI_arvalid,
  output logic                       S00_AXI_arready,
  input  logic [Address_width-1:0]   S01_AXI_araddr,
  input  logic [AXI4_AR_len-1:0]     S01_AXI_arlen,
  input  logic [AR_SIZE_W-1:0]       S01_AXI_arsize,
  input  logic [AR_BURST_W-1:0]      S01_AXI_arburst,
  input  logic [AR_LOCK_W-1:0]       S01_AXI_arlock,
  input  logic [AR_CACHE_W-1:0]      S01_AXI_arcache,
  input  logic [AR_PROT_W-1:0]       S01_AXI_arprot,
  input  logic [AR_QOS_W-1:0]        S01_AXI_arqos,
  input  logic [AR_REGION_W-1:0]     S01_AXI_arregion,
  input  logic                       S01_AXI_arvalid,
  output logic                       S01_AXI_arready,
  output logic [Masters_ID_Size-1:0] Master_AXI_araddr_ID,
  output logic [Address_width-1:0]   Master_AXI_araddr,
  output logic [AXI4_AR_len-1:0]     Master_AXI_arlen,
  output logic [AR_SIZE_W-1:0]       Master_AXI_arsize,
  output logic [AR_BURST_W-1:0]      Master_AXI_arburst,
  output logic [AR_LOCK_W-1:0]       Master_AXI_arlock,
  output logic [AR_CACHE_W-1:0]      Master_AXI_arcache,
  output logic [AR_PROT_W-1:0]       Master_AXI_arprot,
  output logic [AR_QOS_W-1:0]        Master_AXI_arqos,
  output logic [AR_REGION_W-1:0]     Master_AXI_arregion,
  output logic                       Master_AXI_arvalid,
  input  logic                       Sel_Slave_Ready
);

  ar_state_e                  state, state_nxt;
  logic                       last_grant;
  logic [1:0]                 grant;
  logic                       accept;
  ar_attr_t                   attr0, attr1, attr_q;
  logic [Address_width-1:0]   addr_q;
  logic [AXI4_AR_len-1:0]     len_q;
  logic [Masters_ID_Size-1:0] id_q;

  assign attr0 = '{S00_AXI_arsize, S00_AXI_arburst, S00_AXI_arlock, S00_AXI_arcache,
                   S00_AXI_arprot, S00_AXI_arqos, S00_AXI_arregion};
  assign attr1 = '{S01_AXI_arsize, S01_AXI_arburst, S01_AXI_arlock, S01_AXI_arcache,
                   S01_AXI_arprot, S01_AXI_arqos, S01_AXI_arregion};

  ar_rr_arbiter u_arb (
    .valid0     (S00_AXI_arvalid),
    .valid1     (S01_AXI_arvalid),
    .last_grant (last_grant),
`ifdef QOS_ARB_EN
    .qos0       (S00_AXI_arqos),
    .qos1       (S01_AXI_arqos),
`endif
    .grant      (grant)
  );

  // arready depends only on arvalid and state, never on Sel_Slave_Ready.
  always_comb begin
    state_nxt       = state;
    S00_AXI_arready = 1'b0;
    S01_AXI_arready = 1'b0;
    accept          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!ARESET) begin
          S00_AXI_arready = grant[0];
          S01_AXI_arready = grant[1];
          accept          = |grant;
        end
        if (accept) state_nxt = ST_BUSY;
      end
      ST_BUSY: if (Sel_Slave_Ready) state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      state      <= ST_IDLE;
      last_grant <= 1'b1;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      attr_q     <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant[1];
        id_q       <= Masters_ID_Size'(grant[1]);
        addr_q     <= grant[1] ? S01_AXI_araddr : S00_AXI_araddr;
        len_q      <= grant[1] ? S01_AXI_arlen  : S00_AXI_arlen;
        attr_q     <= grant[1] ? attr1 : attr0;
      end
    end
  end

  assign Master_AXI_arvalid   = (state == ST_BUSY);
  assign Master_AXI_araddr_ID = id_q;
  assign Master_AXI_araddr    = addr_q;
  assign Master_AXI_arlen     = len_q;
  assign Master_AXI_arsize    = attr_q.size;
  assign Master_AXI_arburst   = attr_q.burst;
  assign Master_AXI_arlock    = attr_q.lock;
  assign Master_AXI_arcache   = attr_q.cache;
  assign Master_AXI_arprot    = attr_q.prot;
  assign Master_AXI_arqos     = attr_q.qos;
  assign Master_AXI_arregion  = attr_q.region;

endmodule

// File: tb/tb_read_addr_channel_arb.sv
// Directed bench for read_addr_channel_arb: table of per-cycle vectors plus
// hand sequences for reset, reset in BUSY and arqos arbitration.
module tb_read_addr_channel_arb;
  import axi_interconnect_pkg::*;

  localparam logic [31:0] A0 = 32'h1000_0000;
  localparam logic [31:0] A1 = 32'h4000_0010;
`ifdef QOS_ARB_EN
  localparam bit QOS_ON = 1'b1;
`else
  localparam bit QOS_ON = 1'b0;
`endif

  logic        clk = 1'b0, rst = 1'b1;
  logic [31:0] araddr0 = A0, araddr1 = A1;
  logic [7:0]  arlen0 = 8'd7, arlen1 = 8'd3;
  logic [3:0]  arqos0 = 4'd2, arqos1 = 4'd9;
  logic        v0 = 1'b1, v1 = 1'b1, ssr = 1'b0;
  logic        r0, r1, m_valid;
  logic [0:0]  m_id;
  logic [31:0] m_addr;
  logic [7:0]  m_len;
  logic [2:0]  m_size;
  logic [1:0]  m_burst, m_lock;
  logic [3:0]  m_cache, m_qos, m_region;
  logic [2:0]  m_prot;

  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  read_addr_channel_arb dut (
    .ACLK(clk), .ARESET(rst),
    .S00_AXI_araddr(araddr0), .S00_AXI_arlen(arlen0), .S00_AXI_arsize(3'd2),
    .S00_AXI_arburst(2'd1), .S00_AXI_arlock(2'd0), .S00_AXI_arcache(4'h3),
    .S00_AXI_arprot(3'd0), .S00_AXI_arqos(arqos0), .S00_AXI_arregion(4'd1),
    .S00_AXI_arvalid(v0), .S00_AXI_arready(r0),
    .S01_AXI_araddr(araddr1), .S01_AXI_arlen(arlen1), .S01_AXI_arsize(3'd3),
    .S01_AXI_arburst(2'd2), .S01_AXI_arlock(2'd1), .S01_AXI_arcache(4'h5),
    .S01_AXI_arprot(3'd2), .S01_AXI_arqos(arqos1), .S01_AXI_arregion(4'd2),
    .S01_AXI_arvalid(v1), .S01_AXI_arready(r1),
    .Master_AXI_araddr_ID(m_id), .Master_AXI_araddr(m_addr), .Master_AXI_arlen(m_len),
    .Master_AXI_arsize(m_size), .Master_AXI_arburst(m_burst), .Master_AXI_arlock(m_lock),
    .Master_AXI_arcache(m_cache), .Master_AXI_arprot(m_prot), .Master_AXI_arqos(m_qos),
    .Master_AXI_arregion(m_region), .Master_AXI_arvalid(m_valid),
    .Sel_Slave_Ready(ssr)
  );

  typedef struct {
    logic v0, v1, ssr;
    logic r0, r1, mv, id;
    logic [31:0] addr;
    logic [7:0]  len;
  } vec_t;

  vec_t vecs[20];

  function automatic vec_t mk(logic a, logic b, logic s, logic e0, logic e1, logic mv,
                              logic id, logic [31:0] addr, logic [7:0] len);
    vec_t v;
    v.v0 = a; v.v1 = b; v.ssr = s; v.r0 = e0; v.r1 = e1; v.mv = mv;
    v.id = id; v.addr = addr; v.len = len;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_ready(input string tag, input logic e0, input logic e1);
    chk({tag, " S00_arready"}, 32'(r0), 32'(e0));
    chk({tag, " S01_arready"}, 32'(r1), 32'(e1));
  endtask

  logic w1;

  initial begin
    // round-robin contention, single S01 (valid one cycle), backpressure, idle ssr
    vecs[0]  = mk(1,1,1, 1,0,0, 0, 0,  0);
    vecs[1]  = mk(1,1,1, 0,0,1, 0, A0, 7);
    vecs[2]  = mk(1,1,1, 0,1,0, 0, 0,  0);
    vecs[3]  = mk(1,1,1, 0,0,1, 1, A1, 3);
    vecs[4]  = mk(1,1,1, 1,0,0, 0, 0,  0);
    vecs[5]  = mk(1,1,1, 0,0,1, 0, A0, 7);
    vecs[6]  = mk(0,1,1, 0,1,0, 0, 0,  0);
    vecs[7]  = mk(0,0,1, 0,0,1, 1, A1, 3);
    vecs[8]  = mk(0,0,1, 0,0,0, 0, 0,  0);
    vecs[9]  = mk(1,0,0, 1,0,0, 0, 0,  0);
    for (int i = 10; i < 15; i++) vecs[i] = mk(0,1,0, 0,0,1, 0, A0, 7);
    vecs[15] = mk(0,1,1, 0,0,1, 0, A0, 7);
    vecs[16] = mk(0,1,0, 0,1,0, 0, 0,  0);
    vecs[17] = mk(0,0,1, 0,0,1, 1, A1, 3);
    vecs[18] = mk(0,0,0, 0,0,0, 0, 0,  0);
    vecs[19] = mk(0,0,1, 0,0,0, 0, 0,  0);

    // reset held 3 cycles with both masters requesting
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); #1;
      chk_ready("reset", 0, 0);
      chk("reset arvalid", 32'(m_valid), 0);
      chk("reset araddr", m_addr, 0);
      chk("reset id", 32'(m_id), 0);
      chk("reset qos", 32'(m_qos), 0);
    end

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = 1'b0;
      v0 = vecs[i].v0; v1 = vecs[i].v1; ssr = vecs[i].ssr;
      #1;
      chk_ready($sformatf("vec%0d", i), vecs[i].r0, vecs[i].r1);
      chk($sformatf("vec%0d arvalid", i), 32'(m_valid), 32'(vecs[i].mv));
      if (vecs[i].mv) begin
        chk($sformatf("vec%0d id", i), 32'(m_id), 32'(vecs[i].id));
        chk($sformatf("vec%0d araddr", i), m_addr, vecs[i].addr);
        chk($sformatf("vec%0d arlen", i), 32'(m_len), 32'(vecs[i].len));
        chk($sformatf("vec%0d arqos", i), 32'(m_qos), vecs[i].id ? 32'd9 : 32'd2);
      end
    end

    // reset asserted while holding an S00 request: dropped, never replayed
    @(negedge clk); v0 = 1; v1 = 0; ssr = 0; #1;
    chk_ready("rstbusy accept", 1, 0);
    @(negedge clk); #1;
    chk("rstbusy held", 32'(m_valid), 1);
    chk_ready("rstbusy busy", 0, 0);
    rst = 1'b1; #1;
    chk("rstbusy arvalid async", 32'(m_valid), 0);
    chk("rstbusy araddr async", m_addr, 0);
    chk_ready("rstbusy in reset", 0, 0);
    @(negedge clk); rst = 1'b0; v0 = 0; ssr = 1;
    for (int c = 0; c < 3; c++) begin
      #1; chk($sformatf("no replay %0d", c), 32'(m_valid), 0);
      @(negedge clk);
    end

    // arqos arbitration (last_grant=1 after reset)
    w1 = QOS_ON;
    v0 = 1; v1 = 1; ssr = 1; #1;
    chk_ready("qos diff grant", !w1, w1);
    @(negedge clk); #1;
    chk("qos diff id", 32'(m_id), 32'(w1));
    chk("qos diff fwd", 32'(m_qos), w1 ? 32'd9 : 32'd2);
    @(negedge clk); arqos0 = 4'd5; arqos1 = 4'd5; #1;
    chk_ready("qos eq grant a", w1, !w1);
    @(negedge clk); #1;
    chk("qos eq id", 32'(m_id), 32'(!w1));
    chk("qos eq fwd", 32'(m_qos), 32'd5);
    @(negedge clk); #1;
    chk_ready("qos eq grant b", !w1, w1);
    @(negedge clk); v0 = 0; v1 = 0; #1;
    chk("qos eq id b", 32'(m_id), 32'(w1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
